// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache. It sits between the fetch stage
//   and the memory controller. Hits return data in the same cycle. A miss
//   issues one single-word read and fills the selected frame.
//
// Ports
//   CLK, nRST            rising-edge clock, asynchronous active-low reset
//   imemREN, imemaddr    fetch request and byte address from the PC
//   ihit, imemload       same-cycle hit flag and instruction word
//   iREN, iaddr          word read request to the memory controller
//   iwait, iload         memory busy flag; read data is valid when iwait is low
//   hit_count            count of cycles with ihit=1 (wraps at 2^32)
//   miss_count           count of misses serviced (wraps at 2^32)
// -----------------------------------------------------------------------------
module icache_direct #(
    parameter int unsigned FRAMES = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 26
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, next_state;

    // Frame storage. Only the valid bits carry architectural reset state.
    logic [FRAMES-1:0] valid;
    logic [TAG_W-1:0]  tag_mem  [FRAMES];
    logic [31:0]       data_mem [FRAMES];

    // Word address of the miss being serviced. The byte offset is always zero.
    logic [29:0] miss_word;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             lookup_hit;
    logic             miss;
    logic             fill;

    // The byte offset has no meaning for a word-wide instruction cache.
    logic unused_byte_offset;
    assign unused_byte_offset = ^imemaddr[1:0];

    assign req_idx    = imemaddr[IDX_W+1:2];
    assign req_tag    = imemaddr[31:IDX_W+2];
    assign fill_idx   = miss_word[IDX_W-1:0];
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill       = (state == FETCH) && !iwait;
    assign iaddr      = {miss_word, 2'b00};

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'd0;
        iREN       = 1'b0;
        miss       = 1'b0;
        unique case (state)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = data_mem[req_idx];
                    end else begin
                        miss       = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                // The fill completes for the latched address even if the PC
                // moves or the request drops while memory is busy.
                iREN = 1'b1;
                if (!iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_word  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (miss) begin
                miss_word  <= imemaddr[31:2];
                miss_count <= miss_count + 32'd1;
            end
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fill) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays have no reset. A cleared valid bit already
    // makes their contents irrelevant, and leaving out the reset keeps them
    // mappable to RAM. A reset during FETCH forces state to IDLE, so a fill
    // in progress is dropped.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[fill_idx]  <= miss_word[29:IDX_W];
            data_mem[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// -----------------------------------------------------------------------------
// tb_icache_direct
//   Self-checking bench for icache_direct. A reference model holds the cache
//   as a map from frame number to the cached word address. A lazily filled
//   backing memory supplies the data. Each task drives one scenario and checks
//   the results inline.
// -----------------------------------------------------------------------------
module tb_icache_direct;

    localparam int FRAMES = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_direct #(.FRAMES(16), .IDX_W(4), .TAG_W(26)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] mem_data   [logic [29:0]];   // backing memory, word addressed
    logic [29:0] cache_word [int];            // frame number -> cached word
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [29:0] w;
        w = addr[31:2];
        if (!mem_data.exists(w)) mem_data[w] = $urandom;
        return mem_data[w];
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        logic [29:0] w;
        int          f;
        w = addr[31:2];
        f = int'(w) % FRAMES;
        return cache_word.exists(f) && (cache_word[f] == w);
    endfunction

    function automatic void model_fill(input logic [31:0] addr);
        logic [29:0] w;
        w = addr[31:2];
        cache_word[int'(w) % FRAMES] = w;
    endfunction

    // Task entry and exit are 1 time unit after a rising edge.
    task automatic reset_dut();
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        iwait    = 1'b1;
        iload    = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        cache_word.delete();
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
    endtask

    // Presents one fetch and holds it until ihit, as the datapath does.
    // Memory answers after nwait busy cycles. With disturb set, the PC and
    // the request flag change randomly while the fill is pending.
    task automatic fetch_word(input logic [31:0] addr, input int nwait, input bit disturb);
        logic [31:0] exp_data;
        exp_data = mem_word(addr);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        iload    = $urandom;
        @(negedge CLK);
        if (model_hit(addr)) begin
            n_checks++;
            if (ihit !== 1'b1 || imemload !== exp_data) begin
                n_fail++;
                $display("FAIL hit_zero_latency addr=%h: ihit=%b imemload=%h, expected ihit=1 imemload=%h",
                         addr, ihit, imemload, exp_data);
            end
            exp_hits++;
            @(posedge CLK);
            #1;
        end else begin
            n_checks++;
            if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'd0) begin
                n_fail++;
                $display("FAIL miss_detect addr=%h: ihit=%b iREN=%b imemload=%h, expected 0/0/0",
                         addr, ihit, iREN, imemload);
            end
            exp_misses++;
            @(posedge CLK);
            #1;
            for (int k = 0; k <= nwait; k++) begin
                iwait = (k < nwait);
                iload = (k == nwait) ? exp_data : $urandom;
                if (disturb) begin
                    imemaddr = $urandom;
                    imemREN  = 1'($urandom_range(0, 1));
                end
                @(negedge CLK);
                n_checks++;
                if (iREN !== 1'b1 || iaddr !== {addr[31:2], 2'b00} || ihit !== 1'b0 || imemload !== 32'd0) begin
                    n_fail++;
                    $display("FAIL fetch_cycle addr=%h k=%0d: iREN=%b iaddr=%h ihit=%b imemload=%h, expected 1/%h/0/0",
                             addr, k, iREN, iaddr, ihit, imemload, {addr[31:2], 2'b00});
                end
                @(posedge CLK);
                #1;
            end
            iwait    = 1'b1;
            imemREN  = 1'b1;
            imemaddr = addr;
            model_fill(addr);
            @(negedge CLK);
            n_checks++;
            if (ihit !== 1'b1 || imemload !== exp_data || iREN !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_hit addr=%h: ihit=%b imemload=%h iREN=%b, expected 1/%h/0",
                         addr, ihit, imemload, iREN, exp_data);
            end
            exp_hits++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_counters(input string name);
        n_checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            n_fail++;
            $display("FAIL %s counters: hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                     name, hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge CLK);
        n_checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'd0 || imemload !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ihit=%b iREN=%b iaddr=%h imemload=%h, expected all 0",
                     ihit, iREN, iaddr, imemload);
        end
        check_counters("reset");
        @(posedge CLK);
        #1;
    endtask

    task automatic test_first_miss();
        reset_dut();
        mem_data[30'd0] = 32'h3C01_0001;
        fetch_word(32'h0000_0000, 2, 1'b0);
        check_counters("first_miss");
    endtask

    task automatic test_sequential();
        reset_dut();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                fetch_word(32'(i * 4), $urandom_range(0, 3), 1'b0);
            end
        end
        n_checks++;
        if (miss_count !== 32'd16 || hit_count !== 32'd32) begin
            n_fail++;
            $display("FAIL sequential_counts: miss=%0d hit=%0d, expected miss=16 hit=32",
                     miss_count, hit_count);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] m0;
        fetch_word(32'h0000_0000, 1, 1'b0);
        m0 = miss_count;
        fetch_word(32'h0000_0040, 1, 1'b0);
        fetch_word(32'h0000_0000, 0, 1'b0);
        n_checks++;
        if (miss_count !== m0 + 32'd2) begin
            n_fail++;
            $display("FAIL conflict_misses: miss=%0d, expected %0d", miss_count, m0 + 32'd2);
        end
        check_counters("conflict");
    endtask

    task automatic test_redirect();
        reset_dut();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        @(negedge CLK);
        n_checks++;
        if (ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_miss: ihit=%b, expected 0", ihit);
        end
        exp_misses++;
        @(posedge CLK);
        #1;
        imemaddr = 32'h0000_0080;
        iwait    = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL redirect_wait: iREN=%b iaddr=%h, expected 1/00000010", iREN, iaddr);
        end
        @(posedge CLK);
        #1;
        iwait = 1'b0;
        iload = mem_word(32'h0000_0010);
        @(negedge CLK);
        n_checks++;
        if (iaddr !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL redirect_fill_addr: iaddr=%h, expected 00000010", iaddr);
        end
        @(posedge CLK);
        #1;
        iwait = 1'b1;
        model_fill(32'h0000_0010);
        fetch_word(32'h0000_0080, 1, 1'b0);
        fetch_word(32'h0000_0010, 0, 1'b0);
        check_counters("redirect");
    endtask

    task automatic test_reset_mid_fetch();
        fetch_word(32'h0000_0100, 0, 1'b0);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0204;
        iwait    = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        n_checks++;
        if (iREN !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_fetch: iREN=%b, expected 1", iREN);
        end
        #1;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (iREN !== 1'b0 || iaddr !== 32'd0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: iREN=%b iaddr=%h hit=%0d miss=%0d, expected all 0",
                     iREN, iaddr, hit_count, miss_count);
        end
        iload = mem_word(32'h0000_0204);
        iwait = 1'b0;
        @(posedge CLK);
        #1;
        nRST  = 1'b1;
        iwait = 1'b1;
        cache_word.delete();
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
        fetch_word(32'h0000_0204, 1, 1'b0);
        check_counters("refetch_after_reset");
    endtask

    task automatic test_idle_no_req();
        logic [31:0] h0;
        logic [31:0] m0;
        fetch_word(32'h0000_0204, 0, 1'b0);
        h0 = hit_count;
        m0 = miss_count;
        imemREN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (ihit !== 1'b0 || imemload !== 32'd0 || iREN !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_outputs: ihit=%b imemload=%h iREN=%b, expected 0/0/0",
                         ihit, imemload, iREN);
            end
            @(posedge CLK);
            #1;
        end
        n_checks++;
        if (hit_count !== h0 || miss_count !== m0) begin
            n_fail++;
            $display("FAIL idle_counters: hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                     hit_count, miss_count, h0, m0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                imemREN  = 1'b0;
                imemaddr = $urandom;
                @(negedge CLK);
                n_checks++;
                if (ihit !== 1'b0 || iREN !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_idle: ihit=%b iREN=%b, expected 0/0", ihit, iREN);
                end
                @(posedge CLK);
                #1;
            end
            fetch_word({24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        check_counters("random");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        iwait    = 1'b1;
        iload    = 32'd0;
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
        @(posedge CLK);
        #1;
        test_reset();
        test_first_miss();
        test_sequential();
        test_conflict();
        test_redirect();
        test_reset_mid_fetch();
        test_idle_no_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller.
- Fetch side: consumes imemREN/imemaddr from the PC and returns ihit/imemload. The datapath advances the PC only on ihit.
- Memory side: on a miss, issues single-word reads to the memory controller (iREN/iaddr, completion via iwait low) and fills the frame.
- Keeps hit and miss counters for performance checks.

Parameters:
- FRAMES, 16, number of one-word cache frames. Must be a power of two, 2..256.
- IDX_W, 4, index width, equal to log2(FRAMES).
- TAG_W, 26, tag width, equal to 30-IDX_W.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  fetch request valid from datapath.
- imemaddr  in  32  fetch byte address (PC).
- ihit  out  1  requested word is valid on imemload this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  word-aligned read address to memory controller.
- iwait  in  1  memory busy; low means iload is valid this cycle.
- iload  in  32  read data from memory controller.
- hit_count  out  32  number of cycles with ihit=1.
- miss_count  out  32  number of misses serviced.

Behaviour:
- Address split: tag=imemaddr[31:IDX_W+2], index=imemaddr[IDX_W+1:2], bits[1:0] ignored.
- Storage per frame: valid bit, tag, 32-bit data. No dirty bit; the cache is never written by the datapath.
- Reset (async, nRST low):
  - All valid bits 0, state IDLE, latched miss address 0, both counters 0.
  - Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
  - Reset asserted mid-FETCH abandons the fill; no frame is written.
- State IDLE:
  - Hit = imemREN & valid[index] & (tag==stored tag).
  - ihit=hit and imemload=data[index], both combinational, same cycle (zero-latency hit).
  - imemload=0 when not a hit.
  - On a miss (imemREN=1 and not hit): latch {imemaddr[31:2],2'b00} into miss_addr, increment miss_count, go to FETCH next edge.
  - imemREN=0: no hit, no transition, no counting.
- State FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0, imemload=0.
  - iwait=1: remain in FETCH.
  - iwait=0 at the edge: write frame[miss_addr index] with valid=1, tag=miss_addr tag, data=iload; return to IDLE.
- Miss latency: a fresh miss produces ihit on the cycle after the memory's iwait-low cycle, i.e. 2 + (number of iwait-high cycles) cycles after the miss is presented.
- If imemaddr changes during FETCH (e.g. PC redirect), the fill still completes for the latched address. Back in IDLE the new address is evaluated normally.
- If imemREN drops during FETCH, the fill still completes.
- A fill overwrites a conflicting frame unconditionally; no replacement choice exists.
- hit_count increments every cycle ihit=1.
- Both counters wrap modulo 2^32.
- iREN is 0 in IDLE. iaddr holds miss_addr in all states.
- Single outstanding request only; no prefetch.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000000, memory returns iload=0x3C010001 after 2 iwait-high cycles -> iREN=1/iaddr=0x0 for 3 cycles; ihit=1 with imemload=0x3C010001 on the following cycle; miss_count=1, hit_count increments on that cycle.
- Sequential fetch 0x0,0x4,...,0x3C twice -> first pass 16 misses; second pass all hits, each returned with zero latency; miss_count=16, hit_count=32.
- Conflict: fetch 0x00000040 after 0x00000000 (both index 0) -> miss, iaddr=0x40; then re-fetch 0x0 -> miss again; miss_count increments by 2.
- imemaddr changes 0x10 to 0x80 while FETCH is waiting -> fill completes into index 4 with tag for 0x10; 0x80 then misses with iaddr=0x80; re-fetch 0x10 hits.
- nRST pulsed low during FETCH with iwait=1 -> iREN=0 immediately; counters 0; a re-fetch of the same address misses (frame not written).
- imemREN=0 with a valid cached address held -> ihit=0, imemload=0, iREN=0, counters unchanged.
